// File: rtl/call_stack.sv
// call_stack: PIC16C5x return-address stack with level count and sticky overflow/underflow flags
module call_stack #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   stackCommand,
  input  logic [ADDR_WIDTH-1:0]        pushAddr,
  input  logic                         clrFlags,
  output logic [ADDR_WIDTH-1:0]        tos,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;
  localparam int LW = $clog2(DEPTH + 1);
  logic [ADDR_WIDTH-1:0] stk [DEPTH];
  logic isPush, isPop;
  assign isPush = stackCommand == STK_PUSH;
  assign isPop  = stackCommand == STK_POP;
  assign tos    = stk[0];
  assign empty  = level == '0;
  assign full   = level == LW'(DEPTH);
  // Shift entries on push/pop, saturate the level count, and latch sticky flags (set beats clear)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (isPush) begin
        stk[0] <= pushAddr;
        for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
      end else if (isPop) begin
        for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
      end
      level     <= (isPush && !full) ? level + 1'b1 : (isPop && !empty) ? level - 1'b1 : level;
      overflow  <= (isPush && full) || (overflow && !clrFlags);
      underflow <= (isPop && empty) || (underflow && !clrFlags);
    end
endmodule
